// File: rtl/uart_rx.sv
// Oversampled UART receiver: 2-flop synchronizer, start-bit glitch rejection,
// optional parity, 1-2 stop bits, and re-arm on line-high after framing errors.
module uart_rx #(
  parameter int unsigned FRAME_BITS        = 8,
  parameter int unsigned PARITY_BIT        = 2,
  parameter int unsigned STOP_BITS         = 1,
  parameter int unsigned OVERSAMPLE_FACTOR = 13
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  rx,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_busy,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE_FACTOR);
  localparam int unsigned IDX_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE_FACTOR - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(OVERSAMPLE_FACTOR / 2 - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY_BIT == 0);

  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY, STOP_BIT} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_rx_meta;
  logic                  r_rx_s;
  logic [1:0]            r_primed;
  logic                  r_armed;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_par_err;
  logic                  r_ferr;
  logic                  w_sample;
  logic                  w_half;
  logic                  w_done;
  logic                  w_ferr_final;
  logic                  w_par_mismatch;

  assign w_sample = (r_cnt == CNT_LAST);
  assign w_half   = (r_cnt == CNT_HALF);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (!r_rx_s && r_armed) w_state_next = START_BIT;
      START_BIT: if (w_half) w_state_next = r_rx_s ? IDLE : DATA_BITS;
      DATA_BITS: if (w_sample && r_idx == DATA_LAST)
                   w_state_next = (PARITY_BIT < 2) ? PARITY : STOP_BIT;
      PARITY:    if (w_sample) w_state_next = STOP_BIT;
      STOP_BIT:  if (w_sample && r_idx == STOP_LAST) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_busy        = (r_state != IDLE);
    w_done         = (r_state == STOP_BIT) && w_sample && (r_idx == STOP_LAST);
    w_ferr_final   = r_ferr | ~r_rx_s;
    w_par_mismatch = (^r_shift) ^ r_rx_s ^ ODD_PAR;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_primed   <= '0;
      r_armed    <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_ferr     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_primed  <= {r_primed[0], 1'b1};
      rx_valid  <= w_done;

      if (w_state_next != r_state || r_state == IDLE) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else if (w_sample) begin
        r_cnt <= '0;
        r_idx <= r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // The synchronizer's reset value of 1 is not a real line observation,
      // so arming waits until rx_s carries a sampled value.
      if (r_state == IDLE && r_rx_s && r_primed[1]) begin
        r_armed <= 1'b1;
      end else if (w_done && w_ferr_final) begin
        r_armed <= 1'b0;
      end

      if (r_state == DATA_BITS && w_sample) begin
        r_shift <= {r_rx_s, r_shift[FRAME_BITS-1:1]};
      end

      if (r_state == IDLE) begin
        r_par_err <= 1'b0;
        r_ferr    <= 1'b0;
      end else begin
        if (r_state == PARITY && w_sample) r_par_err <= w_par_mismatch;
        if (r_state == STOP_BIT && w_sample) r_ferr <= w_ferr_final;
      end

      if (w_done) begin
        rx_data    <= r_shift;
        parity_err <= r_par_err;
        frame_err  <= w_ferr_final;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8N1 instance and an 8E1 instance driven by
// randomized and directed frames, checked against expectations computed from bit rules.
module tb_uart_rx;

  localparam int OS = 13;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, busy_a, busy_b, perr_a, perr_b, ferr_a, ferr_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcnt_a = 0, vcnt_b = 0;
  int vt_last_a = 0, vt_prev_a = 0;
  frame_t qa[$];
  frame_t qb[$];
  frame_t last_a;

  uart_rx #(.FRAME_BITS(8), .PARITY_BIT(2), .STOP_BITS(1), .OVERSAMPLE_FACTOR(OS)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_busy(busy_a), .parity_err(perr_a), .frame_err(ferr_a));

  uart_rx #(.FRAME_BITS(8), .PARITY_BIT(1), .STOP_BITS(1), .OVERSAMPLE_FACTOR(OS)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_busy(busy_b), .parity_err(perr_b), .frame_err(ferr_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int ch, input logic v);
    if (ch == 1) rx_b = v;
    else rx_a = v;
  endtask

  // Even parity on channel B: total ones over data+parity must be even.
  task automatic send(input int ch, input logic [7:0] d, input logic pb, input logic sb,
                      input int gap, input logic idle_lvl);
    frame_t e;
    logic [7:0] dd;
    dd = d;
    e.data = d;
    e.ferr = ~sb;
    e.perr = (ch == 1) ? ((($countones(d) + int'(pb)) % 2) != 0) : 1'b0;
    if (ch == 1) qb.push_back(e);
    else qa.push_back(e);
    drive(ch, 1'b0); tick(OS);
    for (int i = 0; i < 8; i++) begin
      drive(ch, dd[i]); tick(OS);
    end
    if (ch == 1) begin
      drive(ch, pb); tick(OS);
    end
    drive(ch, sb); tick(OS);
    drive(ch, idle_lvl); tick(gap);
  endtask

  always @(negedge clk) begin
    frame_t e;
    if (valid_a) begin
      vcnt_a++;
      vt_prev_a = vt_last_a;
      vt_last_a = cyc;
      if (qa.size() == 0) chk("unexpected_valid_a", 32'(valid_a), 32'd0);
      else begin
        e = qa.pop_front();
        last_a = e;
        chk("data_a", 32'(data_a), 32'(e.data));
        chk("perr_a", 32'(perr_a), 32'(e.perr));
        chk("ferr_a", 32'(ferr_a), 32'(e.ferr));
      end
    end
    if (valid_b) begin
      vcnt_b++;
      if (qb.size() == 0) chk("unexpected_valid_b", 32'(valid_b), 32'd0);
      else begin
        e = qb.pop_front();
        chk("data_b", 32'(data_b), 32'(e.data));
        chk("perr_b", 32'(perr_b), 32'(e.perr));
        chk("ferr_b", 32'(ferr_b), 32'(e.ferr));
      end
    end
  end

  initial begin
    int v0, busy_cycles;
    logic sb;
    frame_t e;

    tick(3);
    chk("rst_out_a", {data_a, valid_a, busy_a, perr_a, ferr_a}, 32'd0);
    chk("rst_out_b", {data_b, valid_b, busy_b, perr_b, ferr_b}, 32'd0);
    rst_n = 1'b1;
    tick(10);

    send(0, 8'hA5, 1'b0, 1'b1, 10, 1'b1);
    chk("busy_after_a5", 32'(busy_a), 32'd0);
    chk("valid_count_a5", 32'(vcnt_a), 32'd1);

    v0 = vcnt_a;
    busy_cycles = 0;
    rx_a = 1'b0; tick(4); rx_a = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (busy_a) busy_cycles++;
      tick(1);
    end
    chk("glitch_no_valid", 32'(vcnt_a), 32'(v0));
    chk("glitch_busy_brief", 32'(busy_cycles >= 1 && busy_cycles <= OS / 2 + 1), 32'd1);
    chk("glitch_idle", 32'(busy_a), 32'd0);

    v0 = vcnt_a;
    send(0, 8'h3C, 1'b0, 1'b0, 30 * OS, 1'b0);
    chk("ferr_hold_low_one_frame", 32'(vcnt_a), 32'(v0 + 1));
    chk("ferr_hold_low_idle", 32'(busy_a), 32'd0);
    rx_a = 1'b1; tick(20);

    v0 = vcnt_a;
    e.data = 8'h00; e.perr = 1'b0; e.ferr = 1'b1;
    qa.push_back(e);
    rx_a = 1'b0; tick(25 * OS);
    chk("break_one_frame", 32'(vcnt_a), 32'(v0 + 1));
    rx_a = 1'b1; tick(20);

    send(0, 8'h00, 1'b0, 1'b1, 0, 1'b1);
    send(0, 8'hFF, 1'b0, 1'b1, 10, 1'b1);
    chk("b2b_spacing", 32'(vt_last_a - vt_prev_a), 32'(10 * OS));

    send(1, 8'h0F, 1'b1, 1'b1, 10, 1'b1);
    send(1, 8'h0F, 1'b0, 1'b1, 10, 1'b1);

    for (int i = 0; i < 10; i++) begin
      sb = ($urandom_range(0, 3) != 0);
      send(0, 8'($urandom), 1'b0, sb, sb ? $urandom_range(0, 4) : $urandom_range(3, 8), 1'b1);
      sb = ($urandom_range(0, 3) != 0);
      send(1, 8'($urandom), 1'($urandom), sb, sb ? $urandom_range(0, 4) : $urandom_range(3, 8), 1'b1);
    end
    tick(OS * 3);
    chk("hold_data_a", 32'(data_a), 32'(last_a.data));
    chk("hold_ferr_a", 32'(ferr_a), 32'(last_a.ferr));

    v0 = vcnt_a;
    rx_a = 1'b0; tick(4 * OS);
    chk("busy_mid_frame", 32'(busy_a), 32'd1);
    rst_n = 1'b0; tick(3);
    chk("midrst_out_a", {data_a, valid_a, busy_a, perr_a, ferr_a}, 32'd0);
    rst_n = 1'b1; tick(15 * OS);
    chk("midrst_no_valid", 32'(vcnt_a), 32'(v0));
    chk("midrst_idle", 32'(busy_a), 32'd0);
    rx_a = 1'b1; tick(10);
    send(0, 8'h55, 1'b0, 1'b1, 10, 1'b1);
    chk("after_rst_valid", 32'(vcnt_a), 32'(v0 + 1));

    for (int i = 0; i < 2000 && (qa.size() != 0 || qb.size() != 0); i++) tick(1);
    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
